// File: rtl/simplez_run_ctrl.sv
`default_nettype none
// ============================================================================
// simplez_run_ctrl : run/step/halt/restart controller for the Simplez core;
// define SIMPLEZ_RUN_CTRL_DEBOUNCE_EN to add per-button debounce. Rev 1.0
// ============================================================================
module simplez_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int DEB_W      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        halt_btn,
    input  logic        restart_btn,
    input  logic [1:0]  div_sel,
    input  logic        cpu_stop,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic [2:0]  state,
    output logic [15:0] en_cnt
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_HALT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_STEP    = 3'd3,
        ST_STOPPED = 3'd4
    } state_t;

    localparam int C_BTN_RUN     = 0;
    localparam int C_BTN_STEP    = 1;
    localparam int C_BTN_HALT    = 2;
    localparam int C_BTN_RESTART = 3;
    localparam int C_RST_CNT_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [C_RST_CNT_W-1:0] C_RST_LAST = C_RST_CNT_W'(RST_CYCLES - 1);

    if (RST_CYCLES < 1 || DEB_W < 1 || DEB_W > 24) begin : g_param_check
        $error("simplez_run_ctrl: RST_CYCLES or DEB_W out of range");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             w_btn;
    logic [3:0]             r_sync1;
    logic [3:0]             r_sync2;
    logic [3:0]             w_level;
    logic [3:0]             r_prev;
    logic [3:0]             w_req;
    logic [15:0]            r_presc;
    logic [15:0]            w_mask;
    logic                   w_tick;
    logic [C_RST_CNT_W-1:0] r_rst_cnt;

    assign w_btn = {restart_btn, halt_btn, step_btn, run_btn};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef SIMPLEZ_RUN_CTRL_DEBOUNCE_EN
    // A button counts as pressed only after a full counter span of stable-high samples.
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [DEB_W-1:0] r_cnt;
        logic             r_stable;

        always_ff @(posedge clk) begin
            if (!rst_n || !r_sync2[gi]) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (&r_cnt) begin
                r_stable <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_level[gi] = r_stable;
    end
`else
    assign w_level = r_sync2;
`endif

    assign w_req = w_level & ~r_prev;

    always_comb begin
        case (div_sel)
            2'b00:   w_mask = 16'h0000;
            2'b01:   w_mask = 16'h000F;
            2'b10:   w_mask = 16'h00FF;
            default: w_mask = 16'hFFFF;
        endcase
    end

    assign w_tick = ((r_presc & w_mask) == w_mask);

    always_comb begin
        w_state_nxt = r_state;
        cpu_en      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_rst_cnt == C_RST_LAST) w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (w_req[C_BTN_RESTART])    w_state_nxt = ST_INIT;
                else if (cpu_stop)           w_state_nxt = ST_STOPPED;
                else if (w_req[C_BTN_HALT])  w_state_nxt = ST_HALT;
                else if (w_req[C_BTN_STEP])  w_state_nxt = ST_STEP;
                else if (w_req[C_BTN_RUN])   w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A pending halt or restart suppresses the tick in the same cycle.
                cpu_en = w_tick & ~w_req[C_BTN_HALT] & ~w_req[C_BTN_RESTART];
                if (w_req[C_BTN_RESTART])    w_state_nxt = ST_INIT;
                else if (cpu_stop)           w_state_nxt = ST_STOPPED;
                else if (w_req[C_BTN_HALT])  w_state_nxt = ST_HALT;
            end
            ST_STEP: begin
                cpu_en = 1'b1;
                if (w_req[C_BTN_RESTART])    w_state_nxt = ST_INIT;
                else if (cpu_stop)           w_state_nxt = ST_STOPPED;
                else                         w_state_nxt = ST_HALT;
            end
            ST_STOPPED: begin
                if (w_req[C_BTN_RESTART])    w_state_nxt = ST_INIT;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_rst_cnt <= '0;
            r_presc   <= '0;
            en_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_INIT && w_state_nxt == ST_INIT) r_rst_cnt <= r_rst_cnt + 1'b1;
            else                                              r_rst_cnt <= '0;

            // Holding the prescaler at zero outside RUN gives a clean start on entry.
            if (r_state == ST_RUN) r_presc <= r_presc + 16'd1;
            else                   r_presc <= '0;

            if (w_state_nxt == ST_INIT) en_cnt <= '0;
            else if (cpu_en)            en_cnt <= en_cnt + 16'd1;
        end
    end

    assign cpu_rst = (r_state == ST_INIT);
    assign state   = r_state;

endmodule
`default_nettype wire
